// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S ADC capture path.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  localparam int   WORD_BYTES          = 4;
  localparam logic LRCLK_LEFT_LEVEL    = 1'b1;
  localparam int   DEFAULT_SAMPLE_BITS = 24;

  // Byte address of BRAM word number idx.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + idx * 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/i2s_rx_deser.sv
// Serial-to-parallel front end: BCLK/LRCLK edge detection, per-channel bit
// counting, MSB-first shift register and short-channel detection.
// word/word_valid/word_chan/short_err are combinational strobes for the
// cycle in which the event happens; the consumer registers them.
module i2s_rx_deser
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = DEFAULT_SAMPLE_BITS
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   bclk,
  input  logic                   lrclk,
  input  logic                   adcdat,
  input  logic                   rearm,
  output logic [SAMPLE_BITS-1:0] word,
  output logic                   word_valid,
  output logic                   word_chan,
  output logic                   short_err,
  output logic                   lr_rise
);

  localparam int             CW   = 6;
  localparam logic [CW-1:0]  FULL = CW'(SAMPLE_BITS);

  logic                   bclk_q, lrclk_q;
  logic                   chan_q, chan_d;
  logic                   exempt_q, exempt_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS:0]   shift_ext;
  logic                   bclk_rise, lr_edge;

  // Framing: restart on every LRCLK edge, shift on BCLK rise until the word is full.
  always_comb begin
    bclk_rise = bclk & ~bclk_q;
    lr_edge   = lrclk ^ lrclk_q;
    lr_rise   = lr_edge & (lrclk == LRCLK_LEFT_LEVEL);
    // A channel cut short is only an error once we have seen one full frame
    // boundary since reset/arm; the very first channel is usually partial.
    short_err = lr_edge && (bit_cnt_q != '0) && (bit_cnt_q < FULL) && !exempt_q;
    bit_cnt_d = lr_edge ? '0 : bit_cnt_q;
    shift_d   = lr_edge ? '0 : shift_q;
    chan_d    = lr_edge ? lrclk : chan_q;
    exempt_d  = rearm ? 1'b1 : (lr_edge ? 1'b0 : exempt_q);
    shift_ext = {shift_d, adcdat};
    word_valid = 1'b0;
    if (bclk_rise && (bit_cnt_d < FULL)) begin
      shift_d    = shift_ext[SAMPLE_BITS-1:0];
      bit_cnt_d  = bit_cnt_d + CW'(1);
      word_valid = (bit_cnt_d == FULL);
    end
    word      = shift_d;
    word_chan = chan_d;
  end

  // Edge registers and framing state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      chan_q    <= 1'b0;
      exempt_q  <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      bclk_q    <= bclk;
      lrclk_q   <= lrclk;
      chan_q    <= chan_d;
      exempt_q  <= exempt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: rtl/i2s_adc_capture.sv
// WM8731 ADC capture: stereo sample stream plus an optional recording of
// frames into BRAM (left at even word index, right at odd), 32-bit
// left-aligned words matching the playback reader.
module i2s_adc_capture
  import i2s_pkg::*;
#(
  parameter int          SAMPLE_BITS = DEFAULT_SAMPLE_BITS,
  parameter int          NUM_FRAMES  = 15000,
  parameter bit          WRAP        = 1'b0,
  parameter logic [31:0] BASE_ADDR   = 32'd0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i2s_bclk,
  input  logic                   i2s_lrclk,
  input  logic                   i2s_adcdat,
  input  logic                   capture_start,
  input  logic                   capture_stop,
  output logic                   capture_busy,
  output logic                   capture_done,
  output logic                   frame_err,
  output logic                   sample_valid,
  output logic [SAMPLE_BITS-1:0] sample_left,
  output logic [SAMPLE_BITS-1:0] sample_right,
  output logic [31:0]            bram_addrb,
  output logic [31:0]            bram_dinb,
  output logic [3:0]             bram_web,
  output logic                   bram_enb,
  output logic                   bram_clkb,
  output logic                   bram_rstb
);

  localparam logic [31:0] LAST_IDX = 32'(2 * NUM_FRAMES - 1);

  logic [SAMPLE_BITS-1:0] word;
  logic                   word_valid, word_chan, short_err, lr_rise, rearm;
  logic [31:0]            word_ext;

  cap_state_e             state_q, state_d;
  logic [31:0]            idx_q, idx_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   enb_q, enb_d;
  logic [31:0]            addr_q, addr_d, din_q, din_d;
  logic [SAMPLE_BITS-1:0] pend_left_q, pend_left_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [SAMPLE_BITS-1:0] sl_q, sl_d, sr_q, sr_d;
  logic                   sv_q, sv_d;

  i2s_rx_deser #(
    .SAMPLE_BITS(SAMPLE_BITS)
  ) u_deser (
    .clk       (clk),
    .rstn      (rstn),
    .bclk      (i2s_bclk),
    .lrclk     (i2s_lrclk),
    .adcdat    (i2s_adcdat),
    .rearm     (rearm),
    .word      (word),
    .word_valid(word_valid),
    .word_chan (word_chan),
    .short_err (short_err),
    .lr_rise   (lr_rise)
  );

  // Capture FSM and BRAM write generation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ferr_d   = ferr_q | short_err;
    rearm    = 1'b0;
    enb_d    = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    word_ext = 32'(word);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (capture_start) begin
          state_d = ST_SYNC;
          idx_d   = '0;
          ferr_d  = 1'b0;
          rearm   = 1'b1;
        end
      end
      ST_SYNC: begin
        if (capture_stop) state_d = ST_IDLE;
        else if (lr_rise) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (short_err) begin
          // Lost word breaks L/R parity: resync on the next left channel
          // and resume at the start of the current frame.
          state_d = ST_SYNC;
          idx_d   = {idx_q[31:1], 1'b0};
        end else if (word_valid) begin
          enb_d  = 1'b1;
          addr_d = word_addr(BASE_ADDR, idx_q);
          din_d  = word_ext << (32 - SAMPLE_BITS);
          if (idx_q == LAST_IDX) begin
            if (WRAP) idx_d = '0;
            else      state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 32'd1;
          end
        end
        if (capture_stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SYNC) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // Stereo pairing for the sample stream; runs regardless of capture state.
  always_comb begin
    pend_left_d = pend_left_q;
    pend_vld_d  = pend_vld_q & ~short_err;
    sl_d        = sl_q;
    sr_d        = sr_q;
    sv_d        = 1'b0;
    if (word_valid) begin
      if (word_chan == LRCLK_LEFT_LEVEL) begin
        pend_left_d = word;
        pend_vld_d  = 1'b1;
      end else if (pend_vld_q) begin
        sl_d       = pend_left_q;
        sr_d       = word;
        sv_d       = 1'b1;
        pend_vld_d = 1'b0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      enb_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      pend_left_q <= '0;
      pend_vld_q  <= 1'b0;
      sl_q        <= '0;
      sr_q        <= '0;
      sv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      enb_q       <= enb_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      pend_left_q <= pend_left_d;
      pend_vld_q  <= pend_vld_d;
      sl_q        <= sl_d;
      sr_q        <= sr_d;
      sv_q        <= sv_d;
    end
  end

  assign capture_busy = busy_q;
  assign capture_done = done_q;
  assign frame_err    = ferr_q;
  assign sample_valid = sv_q;
  assign sample_left  = sl_q;
  assign sample_right = sr_q;
  assign bram_addrb   = addr_q;
  assign bram_dinb    = din_q;
  assign bram_enb     = enb_q;
  assign bram_web     = {4{enb_q}};
  assign bram_clkb    = clk;
  assign bram_rstb    = 1'b0;

endmodule
